// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control unit: ALUOp classes, R-format function
// codes, ALU_Cnt selects and the multiplier sequencing states.
package alu_pkg;

  localparam logic [1:0] ALUOP_I   = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [4:0] F_AND = 5'b00001;
  localparam logic [4:0] F_OR  = 5'b00010;
  localparam logic [4:0] F_XOR = 5'b00011;
  localparam logic [4:0] F_ADD = 5'b00100;
  localparam logic [4:0] F_SUB = 5'b00111;
  localparam logic [4:0] F_SLT = 5'b01000;
  localparam logic [4:0] F_MUL = 5'b01001;

  // ALU_Cnt is {Bnegate, OP}
  localparam logic [2:0] CNT_AND = 3'b000;
  localparam logic [2:0] CNT_OR  = 3'b001;
  localparam logic [2:0] CNT_XOR = 3'b011;
  localparam logic [2:0] CNT_ADD = 3'b010;
  localparam logic [2:0] CNT_SUB = 3'b110;
  localparam logic [2:0] CNT_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier datapath: one partial product per
// step, fixed DATA_W steps, 2*DATA_W-bit accumulator.
module mul_shift_add #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [DATA_W-1:0]   operand_a,
  input  logic [DATA_W-1:0]   operand_b,
  output logic [2*DATA_W-1:0] acc,
  output logic                last
);

  localparam int ITER_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [ITER_W-1:0]   count;

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge value of acc/mcand/mplier, exactly like the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{DATA_W{1'b0}}, operand_a};
      mplier <= operand_b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  assign last = step && (count == ITER_W'(DATA_W - 1));

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control unit: combinational {ALUOp, Funct} decode plus the sequencer
// that stalls the CPU while the shift-add multiplier runs.
module alu_ctrl_mc
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 5,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [DATA_W-1:0]  operand_a,
  input  logic [DATA_W-1:0]  operand_b,
  output logic [CNT_W-1:0]   ALU_Cnt,
  output logic               illegal_op,
  output logic               stall,
  output logic               mul_done,
  output logic [DATA_W-1:0]  mul_lo,
  output logic [DATA_W-1:0]  mul_hi
);

  state_t              state, state_next;
  logic [2:0]          dec_cnt;
  logic                dec_illegal;
  logic                is_mul;
  logic                funct_hi_zero;
  logic                mul_issue;
  logic                mul_last;
  logic [2*DATA_W-1:0] acc;

  assign funct_hi_zero = ((Funct >> 5) == '0);

  // NOTE: every decode output gets a default before the case; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    dec_cnt     = CNT_AND;
    dec_illegal = 1'b0;
    is_mul      = 1'b0;
    if (valid_in) begin
      case (ALUOp)
        ALUOP_I:  dec_cnt = CNT_ADD;
        ALUOP_BR: dec_cnt = CNT_SUB;
        ALUOP_R: begin
          if (!funct_hi_zero) begin
            dec_illegal = 1'b1;
          end else begin
            case (Funct[4:0])
              F_AND:   dec_cnt = CNT_AND;
              F_OR:    dec_cnt = CNT_OR;
              F_XOR:   dec_cnt = CNT_XOR;
              F_ADD:   dec_cnt = CNT_ADD;
              F_SUB:   dec_cnt = CNT_SUB;
              F_SLT:   dec_cnt = CNT_SLT;
              F_MUL:   is_mul  = 1'b1;
              default: dec_illegal = 1'b1;
            endcase
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign ALU_Cnt   = CNT_W'(dec_cnt);
  assign mul_issue = (state == ST_IDLE) && is_mul;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_issue) state_next = ST_MUL;
      ST_MUL:  if (mul_last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall drops in DONE so the CPU retires the MUL and writes mul_lo that cycle.
  assign stall      = mul_issue || (state == ST_MUL);
  assign mul_done   = (state == ST_DONE);
  assign illegal_op = dec_illegal && (state != ST_MUL);

  mul_shift_add #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_issue),
    .step      (state == ST_MUL),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .acc       (acc),
    .last      (mul_last)
  );

  assign mul_lo = acc[DATA_W-1:0];
  assign mul_hi = acc[2*DATA_W-1:DATA_W];

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Parametrised, multi-cycle ALU control unit for the CPU datapath.
- Decodes {ALUOp, Funct} into the 3-bit ALU_Cnt select for single-cycle operations.
- Adds a branch-compare mode and an illegal-op flag.
- Owns an iterative shift-add multiplier. It stalls the PC/register-write path while a MUL executes, then presents a 2*DATA_W product.

Parameters:
- FUNCT_W, 5, width of Funct field.
- DATA_W, 16, operand width; also the MUL iteration count.
- CNT_W, 3, width of ALU_Cnt.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- valid_in  input  1  an instruction is present this cycle.
- ALUOp  input  2  00 I-format (add), 01 branch (sub), 10 R-format (use Funct), 11 reserved.
- Funct  input  FUNCT_W  R-format function code.
- operand_a  input  DATA_W  rs value (multiplicand).
- operand_b  input  DATA_W  rt value (multiplier).
- ALU_Cnt  output  CNT_W  ALU select {Bnegate, OP}.
- illegal_op  output  1  unsupported encoding decoded this cycle.
- stall  output  1  hold PC and suppress register write.
- mul_done  output  1  one-cycle pulse; product valid.
- mul_lo  output  DATA_W  product bits [DATA_W-1:0].
- mul_hi  output  DATA_W  product bits [2*DATA_W-1:DATA_W].

Behaviour:
- Decode is combinational from ALUOp/Funct/valid_in.
- ALUOp=00 -> ALU_Cnt 010 (add).
- ALUOp=01 -> 110 (sub).
- ALUOp=11 -> 000, illegal_op=1.
- ALUOp=10, by Funct:
  - 00001 -> 000 (and)
  - 00010 -> 001 (or)
  - 00011 -> 011 (xor)
  - 00100 -> 010 (add)
  - 00111 -> 110 (sub)
  - 01000 -> 111 (slt)
  - 01001 -> MUL, ALU_Cnt 000
  - any other Funct -> 000, illegal_op=1.
- illegal_op is gated by valid_in. It is also 0 while in MUL state.
- Funct bits above bit 4 (FUNCT_W>5) must be zero, else illegal.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on valid_in && MUL decode, latch operand_a into mcand (2*DATA_W, zero-extended) and operand_b into mplier, clear acc and iter count, go to MUL.
  - MUL, each cycle: if mplier[0], acc <= acc + mcand. Then mcand <<= 1, mplier >>= 1, count++. After DATA_W cycles (count==DATA_W-1 at the edge), go to DONE.
  - DONE: mul_done=1 for exactly one cycle. acc drives mul_hi/mul_lo. Return to IDLE.
- Arithmetic is unsigned; there is no overflow (acc is 2*DATA_W bits). The iteration counter is $clog2(DATA_W)+1 bits.
- stall = (IDLE && valid_in && MUL decode) || MUL. It is 0 in DONE, so the CPU advances and writes mul_lo that cycle.
- Latency: issue at cycle T, MUL T+1..T+DATA_W, DONE at T+DATA_W+1. That gives DATA_W+1 stall cycles.
- mul_hi/mul_lo hold the last product until the next MUL issue. They are not cleared in DONE->IDLE.
- In MUL, valid_in/ALUOp/Funct/operands are ignored. The CPU holds the instruction stable.
- Reset values: state IDLE, acc 0, count 0, mul_done 0, mul_hi/mul_lo 0, stall 0. ALU_Cnt follows inputs (000 if valid_in=0).
- Reset mid-MUL: state returns to IDLE next edge, partial product discarded, no mul_done pulse.
- Back-to-back MUL: a new MUL decode in the cycle after DONE (IDLE) issues normally.
- Operand of 0: the full DATA_W iterations still run. There is no early termination, so latency is fixed.

Decomposition:
- Shared package alu_pkg:
  - ALUOp encodings (ALUOP_I, ALUOP_BR, ALUOP_R).
  - Funct codes (F_AND, F_OR, F_XOR, F_ADD, F_SUB, F_SLT, F_MUL).
  - ALU_Cnt codes (CNT_AND, CNT_OR, CNT_XOR, CNT_ADD, CNT_SUB, CNT_SLT).
  - FSM state enum.
- One sub-module: mul_shift_add (datapath: mcand/mplier/acc/count registers, load/step/done). alu_ctrl_mc keeps decode and FSM.

Test Plan:
- Reset then valid_in=1, ALUOp=10 with Funct 00001/00010/00011/00100/00111/01000 -> ALU_Cnt 000/001/011/010/110/111; stall=0, illegal_op=0.
- ALUOp=00 -> 010; ALUOp=01 -> 110; ALUOp=11 or Funct=11111 with ALUOp=10 -> ALU_Cnt 000, illegal_op=1. valid_in=0 -> illegal_op=0.
- MUL operand_a=7, operand_b=9 at cycle T -> stall=1 T..T+16; at T+17 stall=0, mul_done=1, mul_lo=0x003F, mul_hi=0x0000; mul_done=0 at T+18.
- MUL 0xFFFF*0xFFFF -> mul_hi=0xFFFE, mul_lo=0x0001. Then MUL 0*0x1234 immediately after -> still 17 stall cycles, result 0.
- Reset asserted at T+5 of a MUL -> next cycle stall=0, mul_done never pulses, mul_hi/mul_lo=0. A subsequent 3*5 yields mul_lo=0x000F.
- During MUL, toggle Funct/operands every cycle -> product equals the values latched at issue, and illegal_op stays 0.
